// File: rtl/aidc_lite_pkg.sv
// Shared constants and bank-state encoding for the compressed-word output buffer.
// Build option: AIDC_LITE_OBUF_STAT_EN adds block counters to aidc_lite_comp_obuf.
package aidc_lite_pkg;

  localparam int WORD_W    = 64;
  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 16;
  localparam int NUM_BANKS = 2;
  localparam int LEN_W     = 5;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2,
    BANK_DRAIN = 2'd3
  } bank_state_e;

  // A bank can take writes only while it has not been closed yet.
  function automatic logic bank_open(input logic [1:0] st);
    return (st == BANK_EMPTY) || (st == BANK_FILL);
  endfunction

endpackage

// File: rtl/aidc_lite_obuf_bank.sv
// One 16x64 buffer bank with written mask, highest written index and fail flag.
// Latency: write visible next cycle; read data is combinational from rd_addr.
module aidc_lite_obuf_bank
  import aidc_lite_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [63:0]       wr_data,
  input  logic              close_en,
  input  logic              close_fail,
  input  logic              drain_en,
  input  logic              release_en,
  input  logic [3:0]        rd_addr,
  output logic [1:0]        state_o,
  output logic [4:0]        len_o,
  output logic              fail_o,
  output logic [63:0]       rd_data_o
);

  bank_state_e             state_q, state_d;
  logic [DEPTH-1:0]        mask_q, mask_d;
  logic [ADDR_W-1:0]       max_q, max_d;
  logic                    fail_q, fail_d;
  logic [WORD_W-1:0]       mem_q [DEPTH];

  // Ordering of the updates lets a write and a close in the same cycle both land.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    max_d   = max_q;
    fail_d  = fail_q;
    if (wr_en) begin
      mask_d[wr_addr] = 1'b1;
      if ((mask_q == '0) || (wr_addr > max_q)) begin
        max_d = wr_addr;
      end
      if (state_q == BANK_EMPTY) begin
        state_d = BANK_FILL;
      end
    end
    if (close_en) begin
      state_d = BANK_FULL;
      fail_d  = close_fail;
    end
    if (drain_en) begin
      state_d = BANK_DRAIN;
    end
    if (release_en) begin
      state_d = BANK_EMPTY;
      mask_d  = '0;
      max_d   = '0;
      fail_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BANK_EMPTY;
      mask_q  <= '0;
      max_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      max_q   <= max_d;
      fail_q  <= fail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_o   = state_q;
    fail_o    = fail_q;
    len_o     = (mask_q == '0) ? 5'd0 : ({1'b0, max_q} + 5'd1);
    rd_data_o = mask_q[rd_addr] ? mem_q[rd_addr] : '0;
  end

endmodule

// File: rtl/aidc_lite_comp_obuf.sv
// Double-banked output buffer: collects BPC-compressed words per block, replays them as sop/eop beats.
// Input has no backpressure (blocks dropped when both banks busy); output is valid/ready. Option: AIDC_LITE_OBUF_STAT_EN.
module aidc_lite_comp_obuf
  import aidc_lite_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [3:0]  addr_i,
  input  logic [63:0] data_i,
  input  logic        done_i,
  input  logic        fail_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_sop_o,
  output logic        m_eop_o,
  output logic        m_comp_o,
  output logic [4:0]  m_len_o,
  output logic [63:0] m_data_o,
  output logic        overflow_o
`ifdef AIDC_LITE_OBUF_STAT_EN
  ,
  output logic [15:0] comp_cnt_o,
  output logic [15:0] fail_cnt_o
`endif
);

  logic                 fill_ptr_q, fill_ptr_d;
  logic                 drain_ptr_q, drain_ptr_d;
  logic [ADDR_W-1:0]    rd_idx_q, rd_idx_d;
  logic                 drop_q, drop_d;
  logic                 overflow_q, overflow_d;

  logic [NUM_BANKS-1:0] wr_en, close_en, drain_en, release_en;
  logic [1:0]           bank_st   [NUM_BANKS];
  logic [LEN_W-1:0]     bank_len  [NUM_BANKS];
  logic                 bank_fail [NUM_BANKS];
  logic [WORD_W-1:0]    bank_data [NUM_BANKS];

  logic                 drop_now;
  logic                 cur_busy;
  logic                 cur_marker;
  logic                 beat_acc;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    aidc_lite_obuf_bank u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[b]),
      .wr_addr    (addr_i),
      .wr_data    (data_i),
      .close_en   (close_en[b]),
      .close_fail (fail_i),
      .drain_en   (drain_en[b]),
      .release_en (release_en[b]),
      .rd_addr    (rd_idx_q),
      .state_o    (bank_st[b]),
      .len_o      (bank_len[b]),
      .fail_o     (bank_fail[b]),
      .rd_data_o  (bank_data[b])
    );
  end

  // Fill side: once a block starts dropping it stays dropped until its done_i.
  always_comb begin
    wr_en      = '0;
    close_en   = '0;
    drop_now   = drop_q || ((valid_i || done_i) && !bank_open(bank_st[fill_ptr_q]));
    if (!drop_now) begin
      wr_en[fill_ptr_q]    = valid_i;
      close_en[fill_ptr_q] = done_i;
    end
    fill_ptr_d = fill_ptr_q ^ (!drop_now && done_i);
    drop_d     = drop_now && !done_i;
    overflow_d = overflow_q || drop_now;
  end

  // Drain side: outputs derive from registered state only, so they hold while stalled.
  always_comb begin
    cur_busy   = (bank_st[drain_ptr_q] == BANK_FULL) || (bank_st[drain_ptr_q] == BANK_DRAIN);
    cur_marker = bank_fail[drain_ptr_q] || (bank_len[drain_ptr_q] == '0);

    m_valid_o = cur_busy;
    m_sop_o   = cur_busy && (rd_idx_q == '0);
    m_eop_o   = cur_busy && (cur_marker ||
                             (({1'b0, rd_idx_q} + 5'd1) == bank_len[drain_ptr_q]));
    m_comp_o  = cur_busy && !cur_marker;
    m_len_o   = m_comp_o ? bank_len[drain_ptr_q] : '0;
    m_data_o  = m_comp_o ? bank_data[drain_ptr_q] : '0;

    beat_acc    = m_valid_o && m_ready_i;
    drain_en    = '0;
    release_en  = '0;
    drain_ptr_d = drain_ptr_q;
    rd_idx_d    = rd_idx_q;
    if (beat_acc) begin
      if (m_eop_o) begin
        release_en[drain_ptr_q] = 1'b1;
        drain_ptr_d             = ~drain_ptr_q;
        rd_idx_d                = '0;
      end else begin
        drain_en[drain_ptr_q]   = 1'b1;
        rd_idx_d                = rd_idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
      rd_idx_q    <= '0;
      drop_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
      rd_idx_q    <= rd_idx_d;
      drop_q      <= drop_d;
      overflow_q  <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;

`ifdef AIDC_LITE_OBUF_STAT_EN
  logic [CNT_W-1:0] comp_cnt_q, comp_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    comp_cnt_d = comp_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (beat_acc && m_eop_o) begin
      if (m_comp_o && (comp_cnt_q != '1)) begin
        comp_cnt_d = comp_cnt_q + 16'd1;
      end
      if (!m_comp_o && (fail_cnt_q != '1)) begin
        fail_cnt_d = fail_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      comp_cnt_q <= comp_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign comp_cnt_o = comp_cnt_q;
  assign fail_cnt_o = fail_cnt_q;
`endif

endmodule

// File: tb/tb_aidc_lite_comp_obuf.sv
// Directed bench for aidc_lite_comp_obuf; inputs change and outputs are sampled on the falling edge.
module tb_aidc_lite_comp_obuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  addr_i;
  logic [63:0] data_i;
  logic        done_i;
  logic        fail_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_sop_o;
  logic        m_eop_o;
  logic        m_comp_o;
  logic [4:0]  m_len_o;
  logic [63:0] m_data_o;
  logic        overflow_o;
`ifdef AIDC_LITE_OBUF_STAT_EN
  logic [15:0] comp_cnt_o;
  logic [15:0] fail_cnt_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  aidc_lite_comp_obuf dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .done_i     (done_i),
    .fail_i     (fail_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_sop_o    (m_sop_o),
    .m_eop_o    (m_eop_o),
    .m_comp_o   (m_comp_o),
    .m_len_o    (m_len_o),
    .m_data_o   (m_data_o),
    .overflow_o (overflow_o)
`ifdef AIDC_LITE_OBUF_STAT_EN
    ,
    .comp_cnt_o (comp_cnt_o),
    .fail_cnt_o (fail_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] beat(input logic sop, input logic eop, input logic comp,
                                       input logic [4:0] len, input logic [63:0] d);
    return {8'h0, 1'b1, sop, eop, comp, len, d};
  endfunction

  function automatic logic [79:0] obs_beat();
    return {8'h0, m_valid_o, m_sop_o, m_eop_o, m_comp_o, m_len_o, m_data_o};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [63:0] d);
    valid_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wr_done(input logic [3:0] a, input logic [63:0] d, input logic f);
    valid_i = 1'b1; addr_i = a; data_i = d; done_i = 1'b1; fail_i = f;
    @(negedge clk);
    valid_i = 1'b0; done_i = 1'b0; fail_i = 1'b0;
  endtask

  task automatic done(input logic f);
    done_i = 1'b1; fail_i = f;
    @(negedge clk);
    done_i = 1'b0; fail_i = 1'b0;
  endtask

  // Waits at most max_wait cycles for a beat, checks it, then lets it be taken (ready=1).
  task automatic expect_beat(input string tag, input int max_wait, input logic [79:0] exp);
    int n = 0;
    while ((m_valid_o !== 1'b1) && (n < max_wait)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, obs_beat(), exp);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; addr_i = '0; data_i = '0;
    done_i = 1'b0; fail_i = 1'b0; m_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {obs_beat()[78:0], overflow_o}, 80'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {obs_beat()[78:0], overflow_o}, 80'h0);

    // Full 4-word block.
    for (int i = 0; i < 4; i++) wr(4'(i), 64'hA0 + 64'(i));
    done(1'b0);
    expect_beat("blk4_b0", 0, beat(1, 0, 1, 5'd4, 64'hA0));
    expect_beat("blk4_b1", 0, beat(0, 0, 1, 5'd4, 64'hA1));
    expect_beat("blk4_b2", 0, beat(0, 0, 1, 5'd4, 64'hA2));
    expect_beat("blk4_b3", 0, beat(0, 1, 1, 5'd4, 64'hA3));
    chk("blk4_idle", {79'h0, m_valid_o}, 80'h0);

    // Hole in the written mask reads as zero.
    wr(4'd0, 64'hA0);
    wr(4'd2, 64'hA2);
    done(1'b0);
    expect_beat("hole_b0", 0, beat(1, 0, 1, 5'd3, 64'hA0));
    expect_beat("hole_b1", 0, beat(0, 0, 1, 5'd3, 64'h0));
    expect_beat("hole_b2", 0, beat(0, 1, 1, 5'd3, 64'hA2));

    // Incompressible block collapses to one marker beat.
    wr(4'd0, 64'h55);
    wr(4'd1, 64'h66);
    done(1'b1);
    expect_beat("fail_marker", 0, beat(1, 1, 0, 5'd0, 64'h0));

    // Block with no writes is also a marker.
    done(1'b0);
    expect_beat("empty_marker", 0, beat(1, 1, 0, 5'd0, 64'h0));

    // Overwrite (last wins) and write coincident with done.
    wr(4'd0, 64'hC0);
    wr(4'd0, 64'hB0);
    wr_done(4'd1, 64'hB1, 1'b0);
    expect_beat("ovw_b0", 0, beat(1, 0, 1, 5'd2, 64'hB0));
    expect_beat("ovw_b1", 0, beat(0, 1, 1, 5'd2, 64'hB1));

    // Three 16-word blocks under stall: two buffered, third dropped.
    m_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) wr(4'(i), 64'h100 + 64'(i));
    done(1'b0);
    for (int i = 0; i < 16; i++) wr(4'(i), 64'h200 + 64'(i));
    done(1'b0);
    chk("no_overflow_two_blocks", {79'h0, overflow_o}, 80'h0);
    for (int i = 0; i < 16; i++) wr(4'(i), 64'h300 + 64'(i));
    done(1'b0);
    chk("overflow_set", {79'h0, overflow_o}, 80'h1);
    chk("stall_hold", obs_beat(), beat(1, 0, 1, 5'd16, 64'h100));
    m_ready_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      expect_beat($sformatf("stream_b%0d", i), 0,
                  beat((i % 16) == 0, (i % 16) == 15, 1'b1, 5'd16,
                       (i < 16) ? 64'h100 + 64'(i) : 64'h200 + 64'(i - 16)));
    end
    chk("stream_end", {79'h0, m_valid_o}, 80'h0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) wr(4'(i), 64'h400 + 64'(i));
    done(1'b0);
    expect_beat("pre_rst_b0", 0, beat(1, 0, 1, 5'd4, 64'h400));
    expect_beat("pre_rst_b1", 0, beat(0, 0, 1, 5'd4, 64'h401));
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {obs_beat()[78:0], overflow_o}, 80'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {obs_beat()[78:0], overflow_o}, 80'h0);
    wr(4'd0, 64'hD0);
    wr(4'd1, 64'hD1);
    done(1'b0);
    expect_beat("post_rst_b0", 0, beat(1, 0, 1, 5'd2, 64'hD0));
    expect_beat("post_rst_b1", 0, beat(0, 1, 1, 5'd2, 64'hD1));
    wr_done(4'd0, 64'hE0, 1'b0);
    expect_beat("single_word", 0, beat(1, 1, 1, 5'd1, 64'hE0));
    wr(4'd3, 64'hF3);
    done(1'b1);
    expect_beat("post_rst_fail", 0, beat(1, 1, 0, 5'd0, 64'h0));
    chk("post_rst_overflow", {79'h0, overflow_o}, 80'h0);
`ifdef AIDC_LITE_OBUF_STAT_EN
    chk("comp_cnt", {64'h0, comp_cnt_o}, 80'd2);
    chk("fail_cnt", {64'h0, fail_cnt_o}, 80'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
